// File: rtl/rob_pkg.sv
// Shared types and default sizing for the multi-commit reorder buffer.
package rob_pkg;

  localparam int unsigned ROB_DEPTH_DEF    = 16;
  localparam int unsigned ROB_N_WB_DEF     = 4;
  localparam int unsigned ROB_COMMIT_W_DEF = 2;
  localparam int unsigned ROB_ARCH_W_DEF   = 5;
  localparam int unsigned ROB_PREG_W_DEF   = 6;
  localparam int unsigned ROB_IDX_W_DEF    = $clog2(ROB_DEPTH_DEF);

  typedef logic [ROB_IDX_W_DEF-1:0] rob_tag_t;
  typedef logic [ROB_IDX_W_DEF:0]   rob_ptr_t;

  // Width-independent control bits, kept apart from the register payload.
  typedef struct packed {
    logic valid;
    logic done;
    logic exc;
    logic has_rd;
  } rob_status_t;

  typedef struct packed {
    rob_status_t                st;
    logic [ROB_ARCH_W_DEF-1:0]  arch_rd;
    logic [ROB_PREG_W_DEF-1:0]  preg;
  } rob_entry_t;

  function automatic logic rob_retirable(input rob_status_t s);
    return s.valid & s.done & ~s.exc;
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Prefix-AND over the oldest COMMIT_W entries: slot valid vector and retire count.
module rob_commit_sel #(
  parameter int COMMIT_W = 2,
  parameter int CNT_W    = $clog2(COMMIT_W + 1)
) (
  input  logic [COMMIT_W-1:0] ready_i,
  input  logic                block_i,
  output logic [COMMIT_W-1:0] slot_valid_o,
  output logic [CNT_W-1:0]    count_o
);

  logic             run;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    run          = ~block_i;
    cnt          = '0;
    slot_valid_o = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      run             = run & ready_i[k];
      slot_valid_o[k] = run;
      cnt             = cnt + CNT_W'(run);
    end
    count_o = cnt;
  end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order alloc, N_WB writeback channels, up to COMMIT_W retires/cycle.
// Optional performance counters are enabled by defining ROB_PERF_CNT_EN.
module rob_multi_commit
  import rob_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH_DEF,
  parameter int N_WB     = ROB_N_WB_DEF,
  parameter int COMMIT_W = ROB_COMMIT_W_DEF,
  parameter int ARCH_W   = ROB_ARCH_W_DEF,
  parameter int PREG_W   = ROB_PREG_W_DEF,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid_i,
  output logic                       alloc_ready_o,
  input  logic                       alloc_has_rd_i,
  input  logic [ARCH_W-1:0]          alloc_arch_rd_i,
  input  logic [PREG_W-1:0]          alloc_preg_i,
  output logic [IDX_W-1:0]           alloc_tag_o,
  input  logic [N_WB-1:0]            wb_valid_i,
  input  logic [N_WB*IDX_W-1:0]      wb_tag_i,
  input  logic [N_WB-1:0]            wb_exc_i,
  output logic [COMMIT_W-1:0]        cmt_valid_o,
  output logic [COMMIT_W-1:0]        cmt_has_rd_o,
  output logic [COMMIT_W*ARCH_W-1:0] cmt_arch_rd_o,
  output logic [COMMIT_W*PREG_W-1:0] cmt_preg_o,
  output logic                       exc_valid_o,
  output logic [IDX_W-1:0]           exc_tag_o,
  input  logic                       flush_in_i,
  output logic [IDX_W:0]             count_o
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                perf_retired_o,
  output logic [31:0]                perf_full_stall_o
`endif
);

  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(COMMIT_W + 1);

  rob_status_t       st_q [DEPTH];
  rob_status_t       st_d [DEPTH];
  logic [ARCH_W-1:0] arch_q [DEPTH];
  logic [PREG_W-1:0] preg_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  count_q, count_d;

  logic [IDX_W-1:0]    head_idx;
  logic [IDX_W-1:0]    tail_idx;
  logic [IDX_W-1:0]    slot_idx [COMMIT_W];
  logic [IDX_W-1:0]    wb_idx   [N_WB];
  logic [COMMIT_W-1:0] slot_ready;
  logic [COMMIT_W-1:0] slot_valid;
  logic [CNT_W-1:0]    retire_cnt;
  logic                full;
  logic                alloc_fire;
  logic                exc_hit;
  logic                kill;

  assign head_idx   = head_q[IDX_W-1:0];
  assign tail_idx   = tail_q[IDX_W-1:0];
  assign full       = (tail_q ^ head_q) == PTR_W'(DEPTH);
  assign alloc_fire = alloc_valid_i & ~full;
  assign exc_hit    = st_q[head_idx].valid & st_q[head_idx].done &
                      st_q[head_idx].exc & ~flush_in_i;
  assign kill       = flush_in_i | exc_hit;

  for (genvar g = 0; g < N_WB; g++) begin : g_wb
    assign wb_idx[g] = wb_tag_i[g*IDX_W +: IDX_W];
  end

  for (genvar g = 0; g < COMMIT_W; g++) begin : g_cmt
    assign slot_idx[g]                      = head_idx + IDX_W'(g);
    assign slot_ready[g]                    = rob_retirable(st_q[slot_idx[g]]);
    assign cmt_has_rd_o[g]                  = st_q[slot_idx[g]].has_rd;
    assign cmt_arch_rd_o[g*ARCH_W +: ARCH_W] = arch_q[slot_idx[g]];
    assign cmt_preg_o[g*PREG_W +: PREG_W]   = preg_q[slot_idx[g]];
  end

  // An excepting head is never retirable, so it also stops the prefix at slot 0.
  rob_commit_sel #(
    .COMMIT_W (COMMIT_W),
    .CNT_W    (CNT_W)
  ) u_commit_sel (
    .ready_i      (slot_ready),
    .block_i      (flush_in_i),
    .slot_valid_o (slot_valid),
    .count_o      (retire_cnt)
  );

  always_comb begin
    st_d    = st_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (kill) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_d[i] = '0;
      end
      tail_d  = head_q;
      count_d = '0;
    end else begin
      for (int i = 0; i < N_WB; i++) begin
        if (wb_valid_i[i] && st_q[wb_idx[i]].valid) begin
          st_d[wb_idx[i]].done = 1'b1;
          st_d[wb_idx[i]].exc  = st_d[wb_idx[i]].exc | wb_exc_i[i];
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (slot_valid[k]) begin
          st_d[slot_idx[k]] = '0;
        end
      end
      // Tail entry is free whenever alloc fires, so this never clobbers a retiring slot.
      if (alloc_fire) begin
        st_d[tail_idx] = '{valid: 1'b1, done: 1'b0, exc: 1'b0, has_rd: alloc_has_rd_i};
      end
      head_d  = head_q + PTR_W'(retire_cnt);
      tail_d  = tail_q + PTR_W'(alloc_fire);
      count_d = count_q + PTR_W'(alloc_fire) - PTR_W'(retire_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      st_q    <= st_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      arch_q[tail_idx] <= alloc_arch_rd_i;
      preg_q[tail_idx] <= alloc_preg_i;
    end
  end

  assign alloc_ready_o = ~full;
  assign alloc_tag_o   = tail_idx;
  assign cmt_valid_o   = slot_valid;
  assign exc_valid_o   = exc_hit;
  assign exc_tag_o     = head_idx;
  assign count_o       = count_q;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_retired_q;
  logic [31:0] perf_stall_q;
  logic [32:0] retired_sum;

  assign retired_sum = {1'b0, perf_retired_q} + 33'(retire_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_retired_q <= retired_sum[32] ? '1 : retired_sum[31:0];
      if (alloc_valid_i && full && !(&perf_stall_q)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_retired_o    = perf_retired_q;
  assign perf_full_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_rob_multi_commit.sv
// Scoreboard bench for rob_multi_commit (default parameters).
`timescale 1ns/1ps
module tb_rob_multi_commit;

  logic        clk;
  logic        rst_n;
  logic        alloc_valid, alloc_ready, alloc_has_rd;
  logic [4:0]  alloc_arch_rd;
  logic [5:0]  alloc_preg;
  logic [3:0]  alloc_tag;
  logic [3:0]  wb_valid, wb_exc;
  logic [15:0] wb_tag;
  logic [1:0]  cmt_valid, cmt_has_rd;
  logic [9:0]  cmt_arch_rd;
  logic [11:0] cmt_preg;
  logic        exc_valid;
  logic [3:0]  exc_tag;
  logic        flush_in;
  logic [4:0]  count;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_retired, perf_full_stall;
`endif

  rob_multi_commit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_valid_i   (alloc_valid),
    .alloc_ready_o   (alloc_ready),
    .alloc_has_rd_i  (alloc_has_rd),
    .alloc_arch_rd_i (alloc_arch_rd),
    .alloc_preg_i    (alloc_preg),
    .alloc_tag_o     (alloc_tag),
    .wb_valid_i      (wb_valid),
    .wb_tag_i        (wb_tag),
    .wb_exc_i        (wb_exc),
    .cmt_valid_o     (cmt_valid),
    .cmt_has_rd_o    (cmt_has_rd),
    .cmt_arch_rd_o   (cmt_arch_rd),
    .cmt_preg_o      (cmt_preg),
    .exc_valid_o     (exc_valid),
    .exc_tag_o       (exc_tag),
    .flush_in_i      (flush_in),
    .count_o         (count)
`ifdef ROB_PERF_CNT_EN
    ,
    .perf_retired_o    (perf_retired),
    .perf_full_stall_o (perf_full_stall)
`endif
  );

  typedef struct {
    logic       has_rd;
    logic [4:0] arch;
    logic [5:0] preg;
    logic [3:0] tag;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         exp_retired = 0;
  int         exp_stall = 0;
  logic [3:0] exp_tail = '0;
  logic [5:0] pcnt = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Retirements and exceptions are checked against the scoreboard at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        if (cmt_valid[k]) begin
          if (k > 0) check_eq("cmt_contig", cmt_valid[k-1], 1);
          check_eq("cmt_sb_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("cmt_payload",
                     {cmt_has_rd[k], cmt_arch_rd[k*5 +: 5], cmt_preg[k*6 +: 6]},
                     {e.has_rd, e.arch, e.preg});
          end
        end
      end
      if (exc_valid) begin
        check_eq("exc_sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          check_eq("exc_tag_sb", exc_tag, sb[0].tag);
          exp_tail    = sb[0].tag;
          exp_retired = exp_retired - sb.size();
          sb.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_clear();
    wb_valid = '0;
    wb_exc   = '0;
    wb_tag   = '0;
  endtask

  task automatic wb_set(input int ch, input logic [3:0] tag, input logic exc);
    wb_valid[ch]       = 1'b1;
    wb_tag[ch*4 +: 4]  = tag;
    wb_exc[ch]         = exc;
  endtask

  task automatic alloc1(input bit acc);
    alloc_valid   = 1'b1;
    alloc_has_rd  = 1'($urandom_range(0, 1));
    alloc_arch_rd = 5'($urandom_range(0, 31));
    alloc_preg    = pcnt;
    #1;
    check_eq("alloc_ready", alloc_ready, acc);
    if (acc) begin
      check_eq("alloc_tag", alloc_tag, exp_tail);
      sb.push_back('{alloc_has_rd, alloc_arch_rd, alloc_preg, exp_tail});
      exp_tail = exp_tail + 4'd1;
      pcnt     = pcnt + 6'd1;
      exp_retired++;
    end else begin
      exp_stall++;
    end
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic discard();
    exp_tail    = exp_tail - 4'(sb.size());
    exp_retired = exp_retired - sb.size();
    sb.delete();
  endtask

  task automatic drain();
    exp_t snap[$];
    int   ch;
    snap = sb;
    ch   = 0;
    foreach (snap[i]) begin
      wb_set(ch, snap[i].tag, 1'b0);
      ch++;
      if (ch == 4) begin
        tick();
        wb_clear();
        ch = 0;
      end
    end
    if (ch != 0) begin
      tick();
      wb_clear();
    end
    for (int i = 0; i < 40 && count != 0; i++) tick();
    check_eq("drain_count", count, 0);
    check_eq("drain_sb", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; alloc_valid = 1'b0; alloc_has_rd = 1'b0; alloc_arch_rd = '0;
    alloc_preg = '0; flush_in = 1'b0;
    wb_clear();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", alloc_ready, 1);
    check_eq("rst_count", count, 0);
    check_eq("rst_cmt", cmt_valid, 0);
    check_eq("rst_exc", exc_valid, 0);
    rst_n = 1'b1;
    tick();

    // Fill to full, then offer three refused allocs.
    for (int i = 0; i < 16; i++) alloc1(1'b1);
    check_eq("full_count", count, 16);
    for (int i = 0; i < 3; i++) alloc1(1'b0);
    check_eq("full_count_hold", count, 16);
    drain();

    // Out-of-order completion; oldest gates retirement.
    for (int i = 0; i < 4; i++) alloc1(1'b1);
    wb_set(0, 4'd3, 1'b0); wb_set(1, 4'd2, 1'b0); wb_set(2, 4'd1, 1'b0);
    tick(); wb_clear();
    check_eq("ooo_cmt0", cmt_valid, 0);
    check_eq("ooo_cnt0", count, 4);
    tick();
    check_eq("ooo_cmt1", cmt_valid, 0);
    wb_set(3, 4'd0, 1'b0);
    tick(); wb_clear();
    check_eq("ooo_cmt2", cmt_valid, 2'b11);
    check_eq("ooo_cnt2", count, 4);
    tick();
    check_eq("ooo_cmt3", cmt_valid, 2'b11);
    check_eq("ooo_cnt3", count, 2);
    tick();
    check_eq("ooo_cmt4", cmt_valid, 0);
    check_eq("ooo_cnt4", count, 0);

    // Advance head to 14, then allocate across the wrap point.
    for (int i = 0; i < 10; i++) alloc1(1'b1);
    drain();
    for (int i = 0; i < 4; i++) alloc1(1'b1);
    wb_set(0, 4'd14, 1'b0); wb_set(1, 4'd15, 1'b0); wb_set(2, 4'd0, 1'b0); wb_set(3, 4'd1, 1'b0);
    tick(); wb_clear();
    check_eq("wrap_cmt0", cmt_valid, 2'b11);
    tick();
    check_eq("wrap_cnt1", count, 2);
    tick();
    check_eq("wrap_cnt2", count, 0);
    check_eq("wrap_tail", alloc_tag, 2);

    // Exception behind a done head; two channels hit the faulting tag.
    for (int i = 0; i < 2; i++) alloc1(1'b1);
    drain();
    for (int i = 0; i < 3; i++) alloc1(1'b1);
    wb_set(0, 4'd4, 1'b0); wb_set(1, 4'd5, 1'b1); wb_set(2, 4'd5, 1'b0);
    tick(); wb_clear();
    check_eq("exc_cmt0", cmt_valid, 2'b01);
    check_eq("exc_v0", exc_valid, 0);
    tick();
    check_eq("exc_v1", exc_valid, 1);
    check_eq("exc_tag", exc_tag, 5);
    check_eq("exc_cmt1", cmt_valid, 0);
    check_eq("exc_cnt1", count, 2);
    tick();
    check_eq("exc_cnt2", count, 0);
    check_eq("exc_v2", exc_valid, 0);
    check_eq("exc_tail", alloc_tag, exp_tail);

    // Flush with a retirable head and a concurrent alloc.
    alloc1(1'b1);
    wb_set(0, 4'd5, 1'b0);
    tick(); wb_clear();
    check_eq("fl_pre_cmt", cmt_valid, 2'b01);
    flush_in = 1'b1; alloc_valid = 1'b1;
    #1;
    check_eq("fl_cmt", cmt_valid, 0);
    check_eq("fl_exc", exc_valid, 0);
    tick();
    flush_in = 1'b0; alloc_valid = 1'b0;
    discard();
    check_eq("fl_cnt", count, 0);
    check_eq("fl_tail", alloc_tag, exp_tail);

    // Writeback to an invalid entry leaves no trace on a later alloc.
    wb_set(0, 4'd5, 1'b1);
    tick(); wb_clear();
    alloc1(1'b1);
    check_eq("stale_cmt", cmt_valid, 0);
    check_eq("stale_exc", exc_valid, 0);
    wb_set(0, 4'd5, 1'b0);
    tick(); wb_clear();
    check_eq("stale_cmt1", cmt_valid, 2'b01);
    check_eq("stale_exc1", exc_valid, 0);
    tick();
    check_eq("stale_cnt", count, 0);

`ifdef ROB_PERF_CNT_EN
    check_eq("perf_retired", perf_retired, exp_retired);
    check_eq("perf_stall", perf_full_stall, exp_stall);
`endif

    // Asynchronous reset in mid-cycle discards everything.
    for (int i = 0; i < 3; i++) alloc1(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_cnt", count, 0);
    check_eq("mrst_ready", alloc_ready, 1);
    check_eq("mrst_cmt", cmt_valid, 0);
    sb.delete();
    exp_tail = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("mrst_tail", alloc_tag, exp_tail);
    check_eq("final_sb", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
Parametrised reorder buffer, successor to the single-commit ROB.
- Sits between rename/dispatch (allocation), N_WB execution writeback channels (completion) and the commit stage.
- Allocates one entry per cycle in program order, marks entries done from any writeback channel, and retires up to COMMIT_W consecutive done entries per cycle.
- Raises a precise exception and self-flushes when a faulting entry reaches the head.

Parameters:
DEPTH, 16, entry count; power of two, >= 4
N_WB, 4, number of writeback channels
COMMIT_W, 2, max entries retired per cycle; 1..DEPTH
ARCH_W, 5, architectural register index width
PREG_W, 6, physical register index width
IDX_W, $clog2(DEPTH), ROB tag width (derived)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
alloc_valid  in  1  dispatch offers one instruction
alloc_ready  out  1  entry free (= !full, from registers only)
alloc_has_rd  in  1  instruction writes a register
alloc_arch_rd  in  ARCH_W  destination architectural register
alloc_preg  in  PREG_W  destination physical register
alloc_tag  out  IDX_W  tag assigned to the current alloc (tail index)
wb_valid  in  N_WB  per-channel completion
wb_tag  in  N_WB*IDX_W  per-channel ROB tag
wb_exc  in  N_WB  per-channel exception flag
cmt_valid  out  COMMIT_W  per-slot retire, slot 0 = oldest
cmt_has_rd  out  COMMIT_W  per-slot writes-register flag
cmt_arch_rd  out  COMMIT_W*ARCH_W  per-slot architectural destination
cmt_preg  out  COMMIT_W*PREG_W  per-slot physical destination
exc_valid  out  1  one-cycle pulse: faulting entry at head
exc_tag  out  IDX_W  tag of the faulting entry
flush_in  in  1  external flush (branch mispredict)
count  out  IDX_W+1  occupied entries

Behaviour:
- Storage: per entry {valid, done, exc, has_rd, arch_rd, preg}. head/tail pointers are IDX_W+1 bits with a wrap bit. full = (tail ^ head) == DEPTH; empty = head == tail.
- Reset (async, rst_n=0): head=tail=0; all valid/done/exc=0; count=0; alloc_ready=1; cmt_valid=0; exc_valid=0.
- Allocation: alloc_valid && alloc_ready at a clock edge writes the entry at tail, sets valid=1, done=0, exc=0, and increments tail.
  - No bypass: when full, alloc is refused even if a commit happens in the same cycle.
- Writeback: each wb_valid[i] sets done=1 on entry wb_tag[i]; exc |= wb_exc[i].
  - A writeback to an entry with valid=0 is ignored.
  - Multiple channels hitting the same tag in the same cycle OR together.
  - Writeback latency to commit visibility is 1 cycle: writeback at edge t, cmt_valid can be asserted in cycle t+1.
- Commit selection: combinational from registered state only. Slot k is valid iff entries head..head+k are all valid && done && !exc, and flush_in=0.
  - Retired count c equals the number of leading ones; head += c at the edge.
  - Wrap-around: indices are taken modulo DEPTH.
- Exception: if the head entry is valid && done && exc, then exc_valid=1 and exc_tag=head[IDX_W-1:0], and no slot commits that cycle (any older entries retired in an earlier cycle). At the next edge all entries are invalidated, tail=head, count=0.
- flush_in: at the next edge all entries are invalidated and tail=head.
  - Takes priority over alloc, writeback and commit in the same cycle.
  - Suppresses cmt_valid and exc_valid combinationally.
- count: registered, updated as count + alloc_fire - c, or 0 on flush/exception.
- Reset asserted mid-operation discards all entries immediately.

Optional Feature:
ROB_PERF_CNT_EN
- Defined: adds outputs perf_retired (32b, += c each cycle) and perf_full_stall (32b, += 1 when alloc_valid && !alloc_ready). Both counters saturate at all-ones and are reset by rst_n only; flush does not clear them.
- Undefined: neither port nor counter exists.

Decomposition:
- Package rob_pkg: rob_entry_t struct, pointer/tag typedefs, DEPTH/N_WB/COMMIT_W defaults.
- Sub-module rob_commit_sel: prefix-AND over the COMMIT_W oldest entries, returning the slot valid vector and retire count.

Test Plan:
- Reset, then alloc 16 instructions without writeback -> alloc_ready=0 at count=16; the 17th alloc_valid is not accepted; tags issued are 0..15.
- Alloc tags 0..3; writeback tags 3,2,1 in one cycle on 3 channels; writeback tag 0 later -> nothing retires until tag 0 is done; then slots {0,1} retire, then {2,3} next cycle; count decreases 4->2->0.
- Fill to tail wrap (head=14): alloc tags 14,15,0,1 and complete all -> retire in order 14,15,0,1; pointer wrap bit toggles.
- Writeback tag 5 with wb_exc=1 while head=4 (done) -> tag 4 retires; next cycle exc_valid=1, exc_tag=5; following cycle count=0 and alloc_tag=5.
- Assert flush_in in the same cycle as an alloc and a commit-eligible head -> cmt_valid=0, the alloc is dropped, count=0 next cycle.
- With ROB_PERF_CNT_EN: retire 10 instructions and stall 3 cycles while full -> perf_retired=10, perf_full_stall=3.
